// File: rtl/en_decode_ctrl.sv
// Decoder sequencing controller: edge-memory initialization, iterative
// decoding with parity-based early termination, and a pseudo-random
// edge-memory address generator.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for START; ITER_CNT/EARLY hold the last decode result
// S_INIT | edge-memory initialization, INIT_CYC cycles
// S_RUN  | decoding iterations until parity streak, limit or ABORT
// S_DONE | one-cycle completion pulse, then back to S_IDLE
module en_decode_ctrl #(
  parameter int INIT_CYC = 16,
  parameter int ETC      = 4,
  parameter int ITER_W   = 10,
  parameter int SEL_W    = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ITER_W-1:0] MAX_ITER,
  input  logic              PARITY_OK,
  output logic              INIT,
  output logic              RUN,
  output logic [SEL_W-1:0]  EM_SEL,
  output logic              BUSY,
  output logic              DONE,
  output logic              EARLY,
  output logic [ITER_W-1:0] ITER_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  localparam logic [15:0] INIT_LOAD = 16'(INIT_CYC - 1);
  localparam logic [7:0]  ETC_V     = 8'(ETC);
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  state_t            state, state_nx;
  logic [15:0]       init_cnt;
  logic [7:0]        par_run;
  logic [7:0]        par_inc;
  logic [ITER_W-1:0] iter_lim;
  logic [ITER_W-1:0] iter_inc;
  logic [7:0]        lfsr;
  logic              accept;
  logic              hit_etc;
  logic              hit_lim;

  // Completion terms evaluated against the values this RUN cycle would produce
  always_comb begin
    iter_inc = ITER_CNT + ITER_W'(1);
    par_inc  = PARITY_OK ? (par_run + 8'd1) : 8'd0;
    hit_etc  = PARITY_OK && (par_inc == ETC_V);
    hit_lim  = (iter_inc == iter_lim);
  end

  // Next-state decode; ABORT outranks completion
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (START && !ABORT) begin
          state_nx = S_INIT;
          accept   = 1'b1;
        end
      end
      S_INIT: begin
        if (ABORT)                state_nx = S_IDLE;
        else if (init_cnt == '0)  state_nx = S_RUN;
      end
      S_RUN: begin
        if (ABORT)                state_nx = S_IDLE;
        else if (hit_etc || hit_lim) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, registered outputs, counters and LFSR
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      INIT     <= 1'b0;
      RUN      <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      EARLY    <= 1'b0;
      ITER_CNT <= '0;
      init_cnt <= '0;
      par_run  <= '0;
      iter_lim <= '0;
      lfsr     <= LFSR_SEED;
    end else begin
      state <= state_nx;
      INIT  <= (state_nx == S_INIT);
      RUN   <= (state_nx == S_RUN);
      DONE  <= (state_nx == S_DONE);
      BUSY  <= (state_nx != S_IDLE);

      if (state == S_INIT || state == S_RUN)
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      case (state)
        S_IDLE: begin
          if (accept) begin
            iter_lim <= (MAX_ITER == '0) ? ITER_W'(1) : MAX_ITER;
            ITER_CNT <= '0;
            EARLY    <= 1'b0;
            par_run  <= '0;
            init_cnt <= INIT_LOAD;
          end
        end
        S_INIT: begin
          if (init_cnt != '0) init_cnt <= init_cnt - 16'd1;
        end
        S_RUN: begin
          if (ABORT) begin
            EARLY <= 1'b0;
          end else begin
            ITER_CNT <= iter_inc;
            par_run  <= par_inc;
            if (hit_etc) EARLY <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign EM_SEL = lfsr[SEL_W-1:0];

endmodule

// File: tb/tb_en_decode_ctrl.sv
// Bench for en_decode_ctrl: directed vector table, hand-written corner
// sequences, and randomized decodes against a trace-level model.
module tb_en_decode_ctrl;

  localparam int INIT_CYC = 16;
  localparam int ETC      = 4;
  localparam int BUDGET   = 2000;

  logic       CLK = 1'b0;
  logic       RST, START, ABORT, PARITY_OK;
  logic [9:0] MAX_ITER;
  logic       INIT, RUN, BUSY, DONE, EARLY;
  logic [2:0] EM_SEL;
  logic [9:0] ITER_CNT;

  int checks   = 0;
  int failures = 0;

  en_decode_ctrl #(.INIT_CYC(INIT_CYC), .ETC(ETC), .ITER_W(10), .SEL_W(3)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .MAX_ITER(MAX_ITER),
    .PARITY_OK(PARITY_OK), .INIT(INIT), .RUN(RUN), .EM_SEL(EM_SEL), .BUSY(BUSY),
    .DONE(DONE), .EARLY(EARLY), .ITER_CNT(ITER_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0] mi;
    int         par_from;     // 0: parity never good, else good from this RUN cycle on
    int         abort_at;     // 0: no abort, else ABORT on this RUN cycle
    bit         start_pulse;  // pulse START on RUN cycle 2
    bit         abort_done;   // raise ABORT during the DONE cycle
    int         exp_run;
    int         exp_iter;
    bit         exp_early;
    int         exp_done;
  } vec_t;

  vec_t tbl[8];
  bit   par_pat[0:1023];
  int   n_init, n_run, n_done, busy_err, steps;
  logic [2:0] em_first[3];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] v = 8'hA5;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  // Walks the RUN-cycle parity trace and reports how the decode ends
  function automatic void model(input int mi, input int abort_at,
                                output int run, output int iter,
                                output bit early, output int done);
    int lim    = (mi == 0) ? 1 : mi;
    int streak = 0;
    run = 0; iter = 0; early = 0; done = 0;
    for (int i = 1; i <= 1023; i++) begin
      if (i == abort_at) begin
        run = i; iter = i - 1; early = 0; done = 0;
        return;
      end
      streak = par_pat[i] ? streak + 1 : 0;
      if (streak == ETC || i == lim) begin
        run = i; iter = i; early = (streak == ETC); done = 1;
        return;
      end
    end
  endfunction

  task automatic run_decode(input logic [9:0] mi, input int abort_at,
                            input bit start_pulse, input bit abort_done);
    int cyc = 0;
    n_init = 0; n_run = 0; n_done = 0;
    @(negedge CLK); START = 1'b1; ABORT = 1'b0; MAX_ITER = mi;
    @(negedge CLK); START = 1'b0;
    MAX_ITER = 10'($urandom_range(0, 1023));
    while (BUSY && cyc < BUDGET) begin
      ABORT = 1'b0; START = 1'b0;
      PARITY_OK = 1'($urandom_range(0, 1));
      if (BUSY !== (INIT | RUN | DONE)) busy_err++;
      if (INIT) begin
        n_init++;
        if (n_init <= 3) em_first[n_init-1] = EM_SEL;
      end
      if (RUN) begin
        n_run++;
        PARITY_OK = par_pat[n_run];
        if (n_run == abort_at) ABORT = 1'b1;
        if (start_pulse && n_run == 2) START = 1'b1;
      end
      if (DONE) begin
        n_done++;
        if (abort_done) ABORT = 1'b1;
      end
      @(negedge CLK);
      cyc++;
    end
    ABORT = 1'b0; START = 1'b0; PARITY_OK = 1'b0;
    chk("decode_in_budget", (cyc < BUDGET) ? 1 : 0, 1);
  endtask

  task automatic check_decode(input string tag, input int e_run, input int e_iter,
                              input bit e_early, input int e_done);
    steps += INIT_CYC + e_run;
    chk({tag, "_init_cycles"}, n_init, INIT_CYC);
    chk({tag, "_run_cycles"}, n_run, e_run);
    chk({tag, "_done_pulses"}, n_done, e_done);
    chk({tag, "_iter_cnt"}, ITER_CNT, e_iter);
    chk({tag, "_early"}, EARLY, e_early);
    chk({tag, "_em_sel"}, EM_SEL, lfsr_after(steps) & 8'h07);
  endtask

  initial begin
    int   e_run, e_iter, e_done, abort_at;
    bit   e_early;
    logic [9:0] mi;

    // mi, par_from, abort_at, start_pulse, abort_done, run, iter, early, done
    tbl[0] = '{10'd10,  0, 0, 1'b0, 1'b0, 10, 10, 1'b0, 1};
    tbl[1] = '{10'd100, 3, 0, 1'b1, 1'b1,  6,  6, 1'b1, 1};
    tbl[2] = '{10'd0,   0, 0, 1'b0, 1'b0,  1,  1, 1'b0, 1};
    tbl[3] = '{10'd100, 0, 4, 1'b0, 1'b0,  4,  3, 1'b0, 0};
    tbl[4] = '{10'd4,   1, 0, 1'b0, 1'b0,  4,  4, 1'b1, 1};
    tbl[5] = '{10'd4,   1, 4, 1'b0, 1'b0,  4,  3, 1'b0, 0};
    tbl[6] = '{10'd1,   1, 0, 1'b1, 1'b0,  1,  1, 1'b0, 1};
    tbl[7] = '{10'd5,   2, 0, 1'b0, 1'b1,  5,  5, 1'b1, 1};

    RST = 1'b1; START = 1'b1; ABORT = 1'b0; PARITY_OK = 1'b0; MAX_ITER = 10'd7;
    busy_err = 0; steps = 0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {INIT, RUN, BUSY, DONE, EARLY, ITER_CNT}, 0);
    chk("reset_em_sel", EM_SEL, 3'b101);
    RST = 1'b0; START = 1'b0;
    @(negedge CLK);
    chk("idle_after_reset_busy", BUSY, 0);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 1024; i++) par_pat[i] = (tbl[v].par_from != 0) && (i >= tbl[v].par_from);
      run_decode(tbl[v].mi, tbl[v].abort_at, tbl[v].start_pulse, tbl[v].abort_done);
      check_decode($sformatf("vec%0d", v), tbl[v].exp_run, tbl[v].exp_iter,
                   tbl[v].exp_early, tbl[v].exp_done);
      if (v == 0) begin
        chk("em_sel_init1", em_first[0], 3'b101);
        chk("em_sel_init2", em_first[1], 3'b010);
        chk("em_sel_init3", em_first[2], 3'b101);
        repeat (5) @(negedge CLK);
        chk("em_sel_idle_hold", EM_SEL, lfsr_after(steps) & 8'h07);
        chk("iter_cnt_idle_hold", ITER_CNT, 10);
      end
    end

    // START together with ABORT in IDLE is ignored
    @(negedge CLK); START = 1'b1; ABORT = 1'b1; MAX_ITER = 10'd3;
    @(negedge CLK); START = 1'b0; ABORT = 1'b0;
    chk("start_abort_idle_busy", BUSY, 0);
    chk("start_abort_idle_init", INIT, 0);
    @(negedge CLK);
    chk("start_abort_idle_em_sel", EM_SEL, lfsr_after(steps) & 8'h07);

    // Reset on the 5th INIT cycle
    @(negedge CLK); START = 1'b1; MAX_ITER = 10'd9;
    @(negedge CLK); START = 1'b0;
    repeat (4) @(negedge CLK);
    chk("init5_before_reset", INIT, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_init_reset_outputs", {INIT, RUN, BUSY, DONE, EARLY, ITER_CNT}, 0);
    chk("mid_init_reset_em_sel", EM_SEL, 3'b101);
    RST = 1'b0; steps = 0;
    repeat (2) @(negedge CLK);
    chk("no_done_after_reset", {DONE, BUSY}, 0);

    // Randomized decodes against the trace model
    for (int t = 0; t < 40; t++) begin
      mi = 10'($urandom_range(0, 20));
      for (int i = 0; i < 1024; i++) par_pat[i] = ($urandom_range(0, 3) != 0);
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 22)) : 0;
      model(int'(mi), abort_at, e_run, e_iter, e_early, e_done);
      run_decode(mi, abort_at, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_decode($sformatf("rnd%0d", t), e_run, e_iter, e_early, e_done);
    end

    chk("busy_matches_phase", busy_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/en_decode_ctrl.md
EN_DECODE_CTRL -- requirements
Module: en_decode_ctrl

Interface
REQ-001 The block SHALL have parameter INIT_CYC, default 16, giving the number of edge-memory initialization cycles (valid range 1..65535).
REQ-002 The block SHALL have parameter ETC, default 4, giving the number of consecutive PARITY_OK cycles that triggers early termination (valid range 1..255).
REQ-003 The block SHALL have parameter ITER_W, default 10, giving the width of the iteration limit and counter.
REQ-004 The block SHALL have parameter SEL_W, default 3, giving the edge-memory address width, equal to log2(EM_S).
REQ-005 The block SHALL have a port CLK, input, 1 bit: single clock (one clock; reset is synchronous and active-high).
REQ-006 The block SHALL have a port RST, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have a port START, input, 1 bit: begin a decode; sampled only in IDLE.
REQ-008 The block SHALL have a port ABORT, input, 1 bit: cancel the decode in progress.
REQ-009 The block SHALL have a port MAX_ITER, input, ITER_W bits: iteration limit, latched on an accepted START.
REQ-010 The block SHALL have a port PARITY_OK, input, 1 bit: all check nodes satisfied this cycle.
REQ-011 The block SHALL have a port INIT, output, 1 bit: edge-memory initialization phase, driven to every equality node.
REQ-012 The block SHALL have a port RUN, output, 1 bit: decoding phase enable.
REQ-013 The block SHALL have a port EM_SEL, output, SEL_W bits: edge-memory address, taken as the LFSR low bits.
REQ-014 The block SHALL have a port BUSY, output, 1 bit: high in INIT, RUN and DONE states.
REQ-015 The block SHALL have a port DONE, output, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have a port EARLY, output, 1 bit: the last decode ended by parity.
REQ-017 The block SHALL have a port ITER_CNT, output, ITER_W bits: number of RUN cycles executed.

Function
REQ-018 The FSM SHALL have states IDLE, INIT, RUN and DONE, and all outputs SHALL be registered.
REQ-019 In IDLE, START=1 and ABORT=0 SHALL cause the next state to be INIT, latch MAX_ITER (0 treated as 1), clear ITER_CNT, clear EARLY and clear the parity run counter.
REQ-020 INIT SHALL be high for exactly INIT_CYC consecutive cycles, and the state SHALL then move to RUN.
REQ-021 RUN SHALL be high for each RUN-state cycle, and ITER_CNT SHALL increment by 1 at the end of each RUN cycle.
REQ-022 The parity run counter SHALL increment on each RUN cycle with PARITY_OK=1 and SHALL clear on each RUN cycle with PARITY_OK=0.
REQ-023 When a RUN cycle brings the parity run counter to ETC, the next state SHALL be DONE and EARLY SHALL be set to 1.
REQ-024 When a RUN cycle brings ITER_CNT to the latched limit, the next state SHALL be DONE with EARLY=0.
REQ-025 If the early-termination and iteration-limit conditions occur in the same cycle, EARLY SHALL be 1.
REQ-026 DONE SHALL last one cycle with DONE=1, and the state SHALL then return to IDLE.
REQ-027 ITER_CNT and EARLY SHALL hold their values in IDLE until the next accepted START.
REQ-028 The LFSR SHALL be 8 bits wide, Fibonacci form, shifting left with new bit0 = b7^b5^b4^b3, with seed 8'hA5.
REQ-029 The LFSR SHALL advance once per cycle while the state is INIT or RUN, and SHALL hold otherwise.
REQ-030 EM_SEL SHALL equal lfsr[SEL_W-1:0].
REQ-031 START outside IDLE SHALL be ignored.
REQ-032 ABORT in INIT or RUN SHALL cause the next state to be IDLE with no DONE pulse, ITER_CNT holding its value and EARLY=0.
REQ-033 ABORT SHALL take priority over completion in the same cycle.
REQ-034 ABORT in IDLE or DONE SHALL have no effect.
REQ-035 ABORT together with START in IDLE SHALL cause START to be ignored.

Reset
REQ-036 RST=1 at any clock edge SHALL force state IDLE; INIT, RUN, BUSY, DONE, EARLY and ITER_CNT to 0; and the LFSR to 8'hA5 (EM_SEL=3'b101).
REQ-037 Reset SHALL take priority over START and ABORT.
REQ-038 Reset mid-operation SHALL abandon the decode with no DONE pulse.

Verification
REQ-039 A bench SHALL verify: reset, then START with MAX_ITER=10 and PARITY_OK=0 -> INIT high 16 cycles, RUN high 10 cycles, one DONE pulse, ITER_CNT=10, EARLY=0.
REQ-040 A bench SHALL verify: MAX_ITER=100, PARITY_OK=1 from the 3rd RUN cycle onward -> DONE after the 6th RUN cycle, ITER_CNT=6, EARLY=1.
REQ-041 A bench SHALL verify: MAX_ITER=0 -> RUN high exactly 1 cycle, ITER_CNT=1.
REQ-042 A bench SHALL verify: after reset, the first three INIT cycles show EM_SEL = 101, 010, 101 (LFSR A5, 4A, 95), and EM_SEL holds in IDLE.
REQ-043 A bench SHALL verify: ABORT on the 4th RUN cycle -> IDLE next cycle, no DONE, ITER_CNT=3, EARLY=0; ABORT in the same cycle as a completion condition -> no DONE.
REQ-044 A bench SHALL verify: START pulsed during RUN is ignored; RST on the 5th INIT cycle -> all outputs 0 next cycle and EM_SEL=101.
